regfile_sb: RTL and testbench

Parametrised integer register file for the pipelined core, with NREAD asynchronous read ports, one synchronous write port and a per-register pending-write scoreboard. Sits between decode (reads, issue) and writeback (write, clear). Asynchronous reset loads the stack-pointer init value. The scoreboard tells decode whether each source operand is still owed by an in-flight instruction.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_sb_scoreboard.sv | 81 ++++++++
 rtl/regfile_sb.sv | 72 +++++++
 tb/tb_regfile_sb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and packed-port helper for the register file slice.
// Optional build macro: REGFILE_BYPASS_EN (same-cycle writeback forwarding).
package regfile_pkg;

   localparam int XLEN_D   = 32;
   localparam int NREG_D   = 32;
   localparam int NREAD_D  = 2;
   localparam int SP_IDX_D = 2;
   localparam logic [31:0] SP_INIT_D = 32'h2ffc;

   localparam int MAXV = 256;
   localparam int MAXF = 64;

   // Port idx of width w from a packed vector (w <= MAXF).
   function automatic logic [MAXF-1:0] get_port(
      input logic [MAXV-1:0] vec,
      input int              idx,
      input int              w
   );
      logic [MAXV-1:0] s;
      s = vec >> (idx * w);
      return s[MAXF-1:0] & ((MAXF'(1) << w) - MAXF'(1));
   endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: busy bits, population count, per-port lookup.
// REGFILE_BYPASS_EN masks busy for a register being written back this cycle.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NREG  = NREG_D,
   parameter  int NREAD = NREAD_D,
   localparam int AW    = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREAD*AW-1:0] rs_addr,
   output logic [NREAD-1:0]    rs_busy,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic                issue_en,
   input  logic [AW-1:0]       issue_rd,
   output logic                issue_waw,
   input  logic                flush,
   output logic [AW:0]         pend_cnt
);

   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_nxt;
   logic [AW:0]     r_cnt;
   logic [AW:0]     w_cnt;
   logic            w_wr_ok;
   logic            w_iss_ok;

   assign w_wr_ok  = wr_en & (wr_addr != '0);
   assign w_iss_ok = issue_en & (issue_rd != '0);

   // Set after clear so a new producer owns the register.
   always_comb begin
      w_busy_nxt = r_busy;
      if (flush) begin
         w_busy_nxt = '0;
      end else begin
         if (w_wr_ok)
            w_busy_nxt[wr_addr] = 1'b0;
         if (w_iss_ok)
            w_busy_nxt[issue_rd] = 1'b1;
      end
   end

   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < NREG; i++)
         w_cnt = w_cnt + (AW+1)'(w_busy_nxt[i]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy <= '0;
         r_cnt  <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_cnt  <= w_cnt;
      end
   end

   assign pend_cnt = r_cnt;

   for (genvar g = 0; g < NREAD; g++) begin : g_rd
      logic [AW-1:0] w_a;
      assign w_a = AW'(get_port(MAXV'(rs_addr), g, AW));
`ifdef REGFILE_BYPASS_EN
      assign rs_busy[g] = r_busy[w_a] & ~(wr_en & (wr_addr == w_a));
`else
      assign rs_busy[g] = r_busy[w_a];
`endif
   end

`ifdef REGFILE_BYPASS_EN
   assign issue_waw = w_iss_ok & r_busy[issue_rd]
                    & ~(wr_en & (wr_addr == issue_rd));
`else
   assign issue_waw = w_iss_ok & r_busy[issue_rd];
`endif

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with async reads, one write port and scoreboard.
// REGFILE_BYPASS_EN enables same-cycle writeback forwarding on reads.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int               XLEN    = XLEN_D,
   parameter  int               NREG    = NREG_D,
   parameter  int               NREAD   = NREAD_D,
   parameter  int               SP_IDX  = SP_IDX_D,
   parameter  logic [XLEN-1:0]  SP_INIT = XLEN'(SP_INIT_D),
   localparam int               AW      = $clog2(NREG)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREAD*AW-1:0]   rs_addr,
   output logic [NREAD*XLEN-1:0] rs_dout,
   output logic [NREAD-1:0]      rs_busy,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [XLEN-1:0]       wr_data,
   input  logic                  issue_en,
   input  logic [AW-1:0]         issue_rd,
   output logic                  issue_waw,
   input  logic                  flush,
   output logic [AW:0]           pend_cnt
);

   logic [XLEN-1:0] r_regs [NREG];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            r_regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end else if (wr_en && (wr_addr != '0)) begin
         r_regs[wr_addr] <= wr_data;
      end
   end

   for (genvar g = 0; g < NREAD; g++) begin : g_rd
      logic [AW-1:0]   w_a;
      logic [XLEN-1:0] w_d;
      assign w_a = AW'(get_port(MAXV'(rs_addr), g, AW));
      always_comb begin
         w_d = r_regs[w_a];
`ifdef REGFILE_BYPASS_EN
         if (wr_en && (wr_addr == w_a))
            w_d = wr_data;
`endif
         if (w_a == '0)
            w_d = '0;
      end
      assign rs_dout[g*XLEN +: XLEN] = w_d;
   end

   rf_scoreboard #(
      .NREG  (NREG),
      .NREAD (NREAD)
   ) u_sb (
      .clk       (clk),
      .reset     (reset),
      .rs_addr   (rs_addr),
      .rs_busy   (rs_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .issue_en  (issue_en),
      .issue_rd  (issue_rd),
      .issue_waw (issue_waw),
      .flush     (flush),
      .pend_cnt  (pend_cnt)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table, model and queue.
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  rs_addr;
   logic [63:0] rs_dout;
   logic [1:0]  rs_busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic        issue_waw;
   logic        flush;
   logic [5:0]  pend_cnt;

   int total = 0;
   int bad   = 0;

   regfile_sb dut (
      .clk       (clk),
      .reset     (reset),
      .rs_addr   (rs_addr),
      .rs_dout   (rs_dout),
      .rs_busy   (rs_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .issue_en  (issue_en),
      .issue_rd  (issue_rd),
      .issue_waw (issue_waw),
      .flush     (flush),
      .pend_cnt  (pend_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        ie;
      logic [4:0]  ird;
      logic        fl;
      logic [4:0]  a0;
      logic [4:0]  a1;
      int          cnt;
   } vec_t;

   typedef struct {
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  busy;
      logic        waw;
   } exp_t;

   vec_t        tbl[16];
   exp_t        q[$];
   logic [31:0] m_reg [32];
   logic [31:0] m_busy;

   function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd,
                               logic ie, logic [4:0] ird, logic fl,
                               logic [4:0] a0, logic [4:0] a1, int cnt);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ird = ird;
      v.fl = fl; v.a0 = a0; v.a1 = a1; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 32; i++)
         m_reg[i] = (i == 2) ? 32'h2ffc : 32'h0;
      m_busy = '0;
   endtask

   function automatic logic hit(logic [4:0] a);
      return BYP && wr_en && (wr_addr == a);
   endfunction

   function automatic logic [31:0] e_dout(logic [4:0] a);
      if (a == 0) return 32'h0;
      if (hit(a)) return wr_data;
      return m_reg[a];
   endfunction

   function automatic logic e_busy(logic [4:0] a);
      return m_busy[a] && !hit(a);
   endfunction

   task automatic m_edge();
      if (wr_en && wr_addr != 0)
         m_reg[wr_addr] = wr_data;
      if (flush) begin
         m_busy = '0;
      end else begin
         if (wr_en && wr_addr != 0) m_busy[wr_addr] = 1'b0;
         if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      end
   endtask

   task automatic drive(vec_t v);
      exp_t e;
      wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
      issue_en = v.ie; issue_rd = v.ird; flush = v.fl;
      rs_addr = {v.a1, v.a0};
      e.d0   = e_dout(v.a0);
      e.d1   = e_dout(v.a1);
      e.busy = {e_busy(v.a1), e_busy(v.a0)};
      e.waw  = issue_en && issue_rd != 0 && m_busy[issue_rd]
               && !hit(issue_rd);
      q.push_back(e);
   endtask

   task automatic check_comb(int n);
      exp_t e;
      if (q.size() == 0) begin
         chk($sformatf("v%0d_queue", n), 32'd0, 32'd1);
         return;
      end
      e = q.pop_front();
      chk($sformatf("v%0d_dout0", n), rs_dout[31:0], e.d0);
      chk($sformatf("v%0d_dout1", n), rs_dout[63:32], e.d1);
      chk($sformatf("v%0d_busy", n), 32'(rs_busy), 32'(e.busy));
      chk($sformatf("v%0d_waw", n), 32'(issue_waw), 32'(e.waw));
   endtask

   task automatic idle();
      wr_en = 0; wr_addr = 0; wr_data = 0;
      issue_en = 0; issue_rd = 0; flush = 0;
   endtask

   initial begin
      idle();
      rs_addr = {5'd0, 5'd2};
      reset = 1'b1;
      m_reset();
      repeat (2) @(negedge clk);
      chk("rst_cnt", 32'(pend_cnt), 32'd0);
      chk("rst_busy", 32'(rs_busy), 32'd0);
      chk("rst_sp", rs_dout[31:0], 32'h2ffc);
      reset = 1'b0;

      tbl[0]  = mk(0, 0, 0,            0, 0, 0, 2, 0, 0);
      tbl[1]  = mk(1, 5, 32'hdeadbeef, 0, 0, 0, 5, 5, 0);
      tbl[2]  = mk(0, 0, 0,            0, 0, 0, 5, 2, 0);
      tbl[3]  = mk(1, 0, 32'h1234,     1, 0, 0, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0,            1, 7, 0, 7, 9, 1);
      tbl[5]  = mk(0, 0, 0,            1, 9, 0, 7, 9, 2);
      tbl[6]  = mk(0, 0, 0,            0, 0, 0, 7, 9, 2);
      tbl[7]  = mk(1, 7, 32'h77,       0, 0, 0, 7, 9, 1);
      tbl[8]  = mk(0, 0, 0,            1, 7, 0, 7, 9, 2);
      tbl[9]  = mk(1, 7, 32'h700,      1, 7, 0, 7, 9, 2);
      tbl[10] = mk(0, 0, 0,            0, 0, 0, 7, 9, 2);
      tbl[11] = mk(0, 0, 0,            1, 3, 0, 3, 9, 3);
      tbl[12] = mk(0, 0, 0,            1, 9, 0, 9, 3, 3);
      tbl[13] = mk(0, 0, 0,            1, 3, 1, 3, 7, 0);
      tbl[14] = mk(0, 0, 0,            0, 0, 0, 3, 9, 0);
      tbl[15] = mk(1, 11, 32'habc,     0, 0, 0, 11, 3, 0);

      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         drive(tbl[n]);
         #1;
         check_comb(n);
         @(posedge clk);
         m_edge();
         #1;
         chk($sformatf("v%0d_cnt", n), 32'(pend_cnt), 32'(tbl[n].cnt));
      end

      // Reset in mid-cycle with work in flight.
      @(negedge clk);
      idle();
      issue_en = 1; issue_rd = 4;
      wr_en = 1; wr_addr = 6; wr_data = 32'h55;
      @(posedge clk);
      #1;
      issue_en = 1; issue_rd = 5;
      #1;
      reset = 1'b1;
      m_reset();
      wr_en = 0;
      issue_rd = 4;
      #1;
      chk("mrst_cnt", 32'(pend_cnt), 32'd0);
      chk("mrst_waw", 32'(issue_waw), 32'd0);
      for (int a = 0; a < 32; a += 2) begin
         rs_addr = {5'(a + 1), 5'(a)};
         #1;
         chk($sformatf("mrst_r%0d", a), rs_dout[31:0],
             (a == 2) ? 32'h2ffc : 32'h0);
         chk($sformatf("mrst_r%0d", a + 1), rs_dout[63:32], 32'h0);
         chk($sformatf("mrst_b%0d", a), 32'(rs_busy), 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      idle();
      rs_addr = {5'd4, 5'd6};
      @(posedge clk);
      #1;
      chk("post_r6", rs_dout[31:0], 32'h0);
      chk("post_b4", 32'(rs_busy), 32'd0);
      chk("post_cnt", 32'(pend_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
